// File: rtl/traffic_light_monitor.sv
// Passive monitor for the red/yellow/green lamp bus: locks onto RED->GREEN->YELLOW,
// tracks per-phase dwell and completed cycles, and latches the first sequencing fault.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int MIN_RED    = 1,
    parameter int MIN_GREEN  = 1,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_DWELL  = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear_fault,
    output logic             locked,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [15:0]      cycle_count,
    output logic             fault,
    output logic [2:0]       fault_code
);

    typedef enum logic [2:0] {
        SYNC,
        S_RED,
        S_GREEN,
        S_YELLOW,
        FAULT
    } state_e;

    typedef enum logic [2:0] {
        CODE_NONE   = 3'd0,
        CODE_ONEHOT = 3'd1,
        CODE_SEQ    = 3'd2,
        CODE_SHORT  = 3'd3,
        CODE_STUCK  = 3'd4
    } code_e;

    // Lamp encoding is {red, yellow, green}.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);

    state_e           state_q, state_d;
    logic [2:0]       lamp_q, lamp_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [15:0]      cycle_q, cycle_d;
    code_e            code_q, code_d;

    logic [2:0]       cur_lamp, succ_lamp;
    state_e           succ_state;
    logic [CNT_W-1:0] min_dwell;
    logic             lamp_onehot;

    assign lamp_d      = {red, yellow, green};
    assign lamp_onehot = (lamp_q == LAMP_R) || (lamp_q == LAMP_Y) || (lamp_q == LAMP_G);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamp_q  <= 3'b000;
            state_q <= SYNC;
            dwell_q <= '0;
            cycle_q <= '0;
            code_q  <= CODE_NONE;
        end else begin
            lamp_q  <= lamp_d;
            state_q <= state_d;
            dwell_q <= dwell_d;
            cycle_q <= cycle_d;
            code_q  <= code_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case
    // leaves a value unassigned and infers a latch.
    always_comb begin
        cur_lamp   = 3'b000;
        succ_lamp  = 3'b000;
        succ_state = SYNC;
        min_dwell  = '0;
        case (state_q)
            S_RED: begin
                cur_lamp   = LAMP_R;
                succ_lamp  = LAMP_G;
                succ_state = S_GREEN;
                min_dwell  = CNT_W'(MIN_RED);
            end
            S_GREEN: begin
                cur_lamp   = LAMP_G;
                succ_lamp  = LAMP_Y;
                succ_state = S_YELLOW;
                min_dwell  = CNT_W'(MIN_GREEN);
            end
            S_YELLOW: begin
                cur_lamp   = LAMP_Y;
                succ_lamp  = LAMP_R;
                succ_state = S_RED;
                min_dwell  = CNT_W'(MIN_YELLOW);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cycle_d = cycle_q;
        code_d  = code_q;
        case (state_q)
            SYNC: begin
                if (lamp_q == LAMP_R) begin
                    state_d = S_RED;
                    dwell_d = CNT_W'(1);
                end
            end
            S_RED, S_GREEN, S_YELLOW: begin
                // Fault checks in priority order; dwell freezes at its current value.
                if (!lamp_onehot) begin
                    state_d = FAULT;
                    code_d  = CODE_ONEHOT;
                end else if ((lamp_q != cur_lamp) && (lamp_q != succ_lamp)) begin
                    state_d = FAULT;
                    code_d  = CODE_SEQ;
                end else if ((lamp_q == succ_lamp) && (dwell_q < min_dwell)) begin
                    state_d = FAULT;
                    code_d  = CODE_SHORT;
                end else if ((lamp_q == cur_lamp) && (dwell_q == MAX_D)) begin
                    state_d = FAULT;
                    code_d  = CODE_STUCK;
                end else if (lamp_q == cur_lamp) begin
                    dwell_d = dwell_q + CNT_W'(1);
                end else begin
                    state_d = succ_state;
                    dwell_d = CNT_W'(1);
                    if (state_q == S_YELLOW) begin
                        cycle_d = cycle_q + 16'd1;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = SYNC;
                    code_d  = CODE_NONE;
                    dwell_d = '0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        phase  = 2'b11;
        fault  = 1'b0;
        case (state_q)
            S_RED:    begin locked = 1'b1; phase = 2'b00; end
            S_GREEN:  begin locked = 1'b1; phase = 2'b01; end
            S_YELLOW: begin locked = 1'b1; phase = 2'b10; end
            FAULT:    fault = 1'b1;
            default:  ;
        endcase
    end

    assign dwell       = dwell_q;
    assign cycle_count = cycle_q;
    assign fault_code  = code_q;

endmodule
